// File: rtl/spi_master_cfg.sv
// spi_master_cfg: SPI master with runtime divider, CPOL/CPHA, bit order
// and one-hot active-low chip selects with setup/hold half-periods.
module spi_master_cfg #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8,
    parameter int NUM_CS = 1,
    parameter int CS_W   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              miso,
    output logic              mosi,
    output logic              sck,
    output logic [NUM_CS-1:0] cs_n,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              new_data
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CS_SETUP,
        TRANSFER,
        CS_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic                half_q, half_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                nd_q, nd_d;
    logic                mosi_q, mosi_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                lsb_q, lsb_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [CS_W-1:0]     cs_q, cs_d;
    logic                half_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            half_q  <= 1'b0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            nd_q    <= 1'b0;
            mosi_q  <= 1'b0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            div_q   <= '0;
            cs_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            nd_q    <= nd_d;
            mosi_q  <= mosi_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
            div_q   <= div_d;
            cs_q    <= cs_d;
        end
    end

    // Counting 0..div_q gives H = clk_div+1 cycles without a wider counter.
    assign half_end = (cnt_q == div_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        nd_d    = 1'b0;
        mosi_d  = mosi_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        lsb_d   = lsb_q;
        div_d   = div_q;
        cs_d    = cs_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CS_SETUP;
                    cnt_d   = '0;
                    half_d  = 1'b0;
                    bit_d   = '0;
                    rx_d    = '0;
                    tx_d    = data_in;
                    mosi_d  = lsb_first ? data_in[0] : data_in[DATA_W-1];
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    lsb_d   = lsb_first;
                    div_d   = clk_div;
                    cs_d    = cs_sel;
                end
            end
            CS_SETUP: begin
                if (half_end) begin
                    state_d = TRANSFER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TRANSFER: begin
                if (!half_end) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!half_q) begin
                    cnt_d  = '0;
                    half_d = 1'b1;
                    rx_d   = lsb_q ? {miso, rx_q[DATA_W-1:1]}
                                   : {rx_q[DATA_W-2:0], miso};
                end else begin
                    cnt_d  = '0;
                    half_d = 1'b0;
                    if (bit_q == BW'(DATA_W - 1)) begin
                        state_d = CS_HOLD;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
                        mosi_d = lsb_q ? tx_q[1] : tx_q[DATA_W-2];
                    end
                end
            end
            CS_HOLD: begin
                if (half_end) begin
                    state_d = IDLE;
                    nd_d    = 1'b1;
                    dout_d  = rx_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign new_data = nd_q;
    assign data_out = dout_q;
    assign mosi     = mosi_q;
    assign sck      = (state_q == TRANSFER) ? (cpol_q ^ cpha_q ^ half_q) : cpol_q;

    always_comb begin
        cs_n = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (busy && (int'(cs_q) == i)) cs_n[i] = 1'b0;
        end
    end

endmodule
